// File: rtl/split_rr_arbiter.sv
// Round-robin bus arbiter for N_INIT initiators plus one split target, with
// split parking, a max-hold preemption timer and a configurable turnaround gap.
module split_rr_arbiter #(
    parameter int N_INIT     = 4,
    parameter int SEL_W      = $clog2(N_INIT + 1),
    parameter int MAX_HOLD   = 64,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_INIT-1:0] req,
    input  logic              req_split,
    input  logic              split_start,
    output logic [N_INIT-1:0] grant,
    output logic              grant_split,
    output logic [SEL_W-1:0]  sel,
    output logic              bus_busy,
    output logic [N_INIT-1:0] parked,
    output logic              preempt
);

    localparam int PTR_W     = $clog2(N_INIT);
    localparam int HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int TURN_LAST = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_S,
        TURN
    } state_e;

    state_e              state_q, state_d;
    logic [N_INIT-1:0]   grant_q, grant_d;
    logic                grant_split_q, grant_split_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                bus_busy_q, bus_busy_d;
    logic [N_INIT-1:0]   parked_q, parked_d;
    logic                preempt_q, preempt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          turn_q, turn_d;

    logic                release_bus;
    logic                arb_now;
    logic [N_INIT-1:0]   others;
    logic [N_INIT-1:0]   elig_next;
    logic                split_ok;
    logic                split_next;
    logic                found;
    int                  pick;
    int                  idx;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        grant_split_d = grant_split_q;
        sel_d         = sel_q;
        bus_busy_d    = bus_busy_q;
        parked_d      = parked_q;
        preempt_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        turn_d        = turn_q;
        release_bus   = 1'b0;
        found         = 1'b0;
        pick          = 0;
        idx           = 0;

        split_ok = req_split && (parked_q != '0);
        others   = req & ~parked_q & ~grant_q;

        case (state_q)
            GNT_I: begin
                if (split_start && (parked_q == '0)) begin
                    parked_d    = parked_q | grant_q;
                    release_bus = 1'b1;
                end else if ((req & grant_q) == '0) begin
                    release_bus = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_LAST)) &&
                             ((others != '0) || split_ok)) begin
                    preempt_d   = 1'b1;
                    release_bus = 1'b1;
                end else if (hold_q != HOLD_W'(HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GNT_S: begin
                if (!req_split) begin
                    parked_d    = '0;
                    release_bus = 1'b1;
                end
            end
            TURN: begin
                if (turn_q != 2'd0) turn_d = turn_q - 2'd1;
            end
            default: ;
        endcase

        if (release_bus) begin
            grant_d       = '0;
            grant_split_d = 1'b0;
            bus_busy_d    = 1'b0;
            state_d       = TURN;
            turn_d        = 2'(TURN_LAST);
        end

        // The last turnaround cycle doubles as the arbitration slot, so the
        // gap seen on the bus is exactly TURNAROUND cycles.
        arb_now = (state_q == IDLE) || ((state_q == TURN) && (turn_q == 2'd0)) ||
                  (release_bus && (TURNAROUND == 0));

        elig_next  = req & ~parked_d;
        split_next = req_split && (parked_d != '0);

        for (int i = 0; i < N_INIT; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_INIT) idx = idx - N_INIT;
            if (!found && elig_next[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        if (arb_now) begin
            state_d = IDLE;
            if (split_next) begin
                state_d       = GNT_S;
                grant_d       = '0;
                grant_split_d = 1'b1;
                sel_d         = SEL_W'(N_INIT);
                bus_busy_d    = 1'b1;
            end else if (found) begin
                state_d       = GNT_I;
                grant_d       = '0;
                grant_d[pick] = 1'b1;
                grant_split_d = 1'b0;
                sel_d         = SEL_W'(pick);
                bus_busy_d    = 1'b1;
                ptr_d         = (pick == N_INIT - 1) ? '0 : PTR_W'(pick + 1);
                hold_d        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge value regardless of statement order.
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_split_q <= 1'b0;
            sel_q         <= '0;
            bus_busy_q    <= 1'b0;
            parked_q      <= '0;
            preempt_q     <= 1'b0;
            ptr_q         <= '0;
            hold_q        <= '0;
            turn_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_split_q <= grant_split_d;
            sel_q         <= sel_d;
            bus_busy_q    <= bus_busy_d;
            parked_q      <= parked_d;
            preempt_q     <= preempt_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            turn_q        <= turn_d;
        end
    end

    assign grant       = grant_q;
    assign grant_split = grant_split_q;
    assign sel         = sel_q;
    assign bus_busy    = bus_busy_q;
    assign parked      = parked_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_split_rr_arbiter.sv
// Scoreboard bench for split_rr_arbiter (N_INIT=4, MAX_HOLD=8, TURNAROUND=1):
// each step queues the expected post-edge outputs and compares them after the edge.
module tb_split_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       req_split;
    logic       split_start;
    logic [3:0] grant;
    logic       grant_split;
    logic [2:0] sel;
    logic       bus_busy;
    logic [3:0] parked;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic       gs;
        logic [2:0] sl;
        logic       busy;
        logic [3:0] pk;
        logic       pre;
    } exp_t;

    exp_t sb_q[$];

    split_rr_arbiter #(
        .N_INIT    (4),
        .MAX_HOLD  (8),
        .TURNAROUND(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_split  (req_split),
        .split_start(split_start),
        .grant      (grant),
        .grant_split(grant_split),
        .sel        (sel),
        .bus_busy   (bus_busy),
        .parked     (parked),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered outputs,
    // then compare them just after the clock edge.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic rs, input logic ss, input logic [3:0] g,
                        input logic gs, input logic [2:0] sl, input logic [3:0] pk,
                        input logic pre);
        exp_t e;
        rst         = r;
        req         = rq;
        req_split   = rs;
        split_start = ss;
        e.g    = g;
        e.gs   = gs;
        e.sl   = sl;
        e.busy = (|g) | gs;
        e.pk   = pk;
        e.pre  = pre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".grant"}, 32'(grant), 32'(e.g));
        check({tag, ".grant_split"}, 32'(grant_split), 32'(e.gs));
        check({tag, ".sel"}, 32'(sel), 32'(e.sl));
        check({tag, ".bus_busy"}, 32'(bus_busy), 32'(e.busy));
        check({tag, ".parked"}, 32'(parked), 32'(e.pk));
        check({tag, ".preempt"}, 32'(preempt), 32'(e.pre));
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] oh;

        rst = 1'b1; req = '0; req_split = 1'b0; split_start = 1'b0;

        // Reset, single request, release, one-cycle gap.
        step("reset",      1, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        step("single_gnt", 0, 4'b0001, 0, 0, 4'b0001, 0, 3'd0, 4'b0000, 0);
        step("single_rel", 0, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        step("single_idl", 0, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);

        // Round-robin rotation with all four requesting.
        step("rr_reset",   1, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order[i];
            step("rr_grant", 0, 4'b1111, 0, 0, oh, 0, 3'(order[i]), 4'b0000, 0);
            step("rr_hold1", 0, 4'b1111, 0, 0, oh, 0, 3'(order[i]), 4'b0000, 0);
            step("rr_hold2", 0, 4'b1111, 0, 0, oh, 0, 3'(order[i]), 4'b0000, 0);
            step("rr_gap",   0, 4'b1111 & ~oh, 0, 0, 4'b0000, 0, 3'(order[i]), 4'b0000, 0);
        end
        step("rr_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);

        // Split parking of initiator 2, then split target service.
        step("sp_reset",   1, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        step("sp_gnt2",    0, 4'b0100, 0, 0, 4'b0100, 0, 3'd2, 4'b0000, 0);
        step("sp_park",    0, 4'b0101, 0, 1, 4'b0000, 0, 3'd2, 4'b0100, 0);
        step("sp_gnt0",    0, 4'b0101, 0, 0, 4'b0001, 0, 3'd0, 4'b0100, 0);
        step("sp_ign_ss",  0, 4'b0101, 1, 1, 4'b0001, 0, 3'd0, 4'b0100, 0);
        step("sp_rel0",    0, 4'b0100, 1, 0, 4'b0000, 0, 3'd0, 4'b0100, 0);
        step("sp_gnt_s",   0, 4'b0100, 1, 0, 4'b0000, 1, 3'd4, 4'b0100, 0);
        step("sp_hold_s",  0, 4'b0100, 1, 0, 4'b0000, 1, 3'd4, 4'b0100, 0);
        step("sp_rel_s",   0, 4'b0100, 0, 0, 4'b0000, 0, 3'd4, 4'b0000, 0);
        step("sp_unpark2", 0, 4'b0100, 0, 0, 4'b0100, 0, 3'd2, 4'b0000, 0);
        step("sp_rel2",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd2, 4'b0000, 0);
        step("sp_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd2, 4'b0000, 0);

        // MAX_HOLD preemption with a competitor on initiator 3.
        step("mh_reset",   1, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        step("mh_gnt1",    0, 4'b1010, 0, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        for (int i = 2; i <= 8; i++)
            step("mh_hold", 0, 4'b1010, 0, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        step("mh_preempt", 0, 4'b1010, 0, 0, 4'b0000, 0, 3'd1, 4'b0000, 1);
        step("mh_gnt3",    0, 4'b1010, 0, 0, 4'b1000, 0, 3'd3, 4'b0000, 0);
        step("mh_rel3",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd3, 4'b0000, 0);
        step("mh_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd3, 4'b0000, 0);

        // No competitor: grant held well past MAX_HOLD, then saturated preempt.
        step("nc_gnt1",    0, 4'b0010, 0, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        for (int i = 0; i < 21; i++)
            step("nc_hold", 0, 4'b0010, 0, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        step("nc_preempt", 0, 4'b1010, 0, 0, 4'b0000, 0, 3'd1, 4'b0000, 1);
        step("nc_gnt3",    0, 4'b1010, 0, 0, 4'b1000, 0, 3'd3, 4'b0000, 0);
        step("nc_rel3",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd3, 4'b0000, 0);
        step("nc_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd3, 4'b0000, 0);

        // req_split without a parked initiator is ignored; sel holds last owner.
        for (int i = 0; i < 4; i++)
            step("rs_ignored", 0, 4'b0000, 1, 0, 4'b0000, 0, 3'd3, 4'b0000, 0);

        // split_start coincident with req falling still parks.
        step("co_gnt1",    0, 4'b0010, 0, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        step("co_park",    0, 4'b0000, 0, 1, 4'b0000, 0, 3'd1, 4'b0010, 0);
        step("co_gnt_s",   0, 4'b0000, 1, 0, 4'b0000, 1, 3'd4, 4'b0010, 0);
        step("co_ign_ss",  0, 4'b0000, 1, 1, 4'b0000, 1, 3'd4, 4'b0010, 0);

        // Reset during GNT_S, then pointer restarts at initiator 0.
        step("rg_reset",   1, 4'b0000, 1, 0, 4'b0000, 0, 3'd0, 4'b0000, 0);
        step("rg_gnt1",    0, 4'b1010, 1, 0, 4'b0010, 0, 3'd1, 4'b0000, 0);
        step("rg_rel1",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd1, 4'b0000, 0);
        step("rg_idle",    0, 4'b0000, 0, 0, 4'b0000, 0, 3'd1, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
